// File: rtl/shift_register_ctrl.sv
// Two-requester round-robin byte serializer driving an external 8-stage
// shift register: MSB-first serial data, divided shift strobe, latch pulse.
module shift_register_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk_sr,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       sr_data,
    output logic       sr_shift,
    output logic       sr_latch,
    output logic       busy,
    output logic       grant_id
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DIV_W  = 8;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_id_q, grant_id_d;
    logic                sr_data_q, sr_data_d;
    logic                sr_shift_q, sr_shift_d;
    logic                sr_latch_q, sr_latch_d;
    logic                busy_q, busy_d;
    logic                accept_a, accept_b;

    // Round-robin arbitration: only in IDLE; on a tie the side not served last wins
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state_q == ST_IDLE) begin
            if (a_valid && b_valid) begin
                a_ready = last_grant_q;
                b_ready = ~last_grant_q;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign accept_a = a_valid & a_ready;
    assign accept_b = b_valid & b_ready;

    // State and datapath registers, plus registered outputs
    always_ff @(posedge clk_sr or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            sr_data_q    <= 1'b0;
            sr_shift_q   <= 1'b0;
            sr_latch_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            sr_data_q    <= sr_data_d;
            sr_shift_q   <= sr_shift_d;
            sr_latch_q   <= sr_latch_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state: capture on handshake, divide, shift MSB-first, one LATCH cycle
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_a || accept_b) begin
                    shreg_d      = accept_b ? b_data : a_data;
                    grant_id_d   = accept_b;
                    last_grant_d = accept_b;
                    bit_cnt_d    = '0;
                    div_cnt_d    = '0;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_LATCH;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs leave a flop aligned with it
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        sr_data_d  = (state_d == ST_SHIFT) && shreg_d[DATA_W-1];
        sr_shift_d = (state_d == ST_SHIFT) && (div_cnt_d == DIV_LAST);
        sr_latch_d = (state_d == ST_LATCH);
    end

    assign sr_data  = sr_data_q;
    assign sr_shift = sr_shift_q;
    assign sr_latch = sr_latch_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Self-checking bench for shift_register_ctrl: DIV=4 main instance plus a DIV=2 instance.
module tb_shift_register_ctrl;
    localparam int unsigned DIV  = 4;
    localparam int unsigned DIV2 = 2;

    logic clk_sr = 1'b0;
    logic rst;

    logic       a_valid, b_valid, a_ready, b_ready;
    logic [7:0] a_data, b_data;
    logic       sr_data, sr_shift, sr_latch, busy, grant_id;

    logic       d2_a_valid, d2_b_valid, d2_a_ready, d2_b_ready;
    logic [7:0] d2_a_data, d2_b_data;
    logic       d2_sr_data, d2_sr_shift, d2_sr_latch, d2_busy, d2_grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_last   = 1'b1;   // reference model: last granted requester (1 = B)

    always #5 clk_sr = ~clk_sr;

    shift_register_ctrl #(.DIV(DIV)) dut (
        .clk_sr(clk_sr), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .sr_data(sr_data), .sr_shift(sr_shift), .sr_latch(sr_latch),
        .busy(busy), .grant_id(grant_id)
    );

    shift_register_ctrl #(.DIV(DIV2)) dut2 (
        .clk_sr(clk_sr), .rst(rst),
        .a_valid(d2_a_valid), .a_data(d2_a_data), .a_ready(d2_a_ready),
        .b_valid(d2_b_valid), .b_data(d2_b_data), .b_ready(d2_b_ready),
        .sr_data(d2_sr_data), .sr_shift(d2_sr_shift), .sr_latch(d2_sr_latch),
        .busy(d2_busy), .grant_id(d2_grant_id)
    );

    // Move to 2 time units after the next rising edge (inputs are driven here)
    task automatic step();
        @(posedge clk_sr);
        #2;
    endtask

    // Expected {a_ready, b_ready} in IDLE from the arbitration rules
    function automatic logic [1:0] exp_ready(input logic av, input logic bv);
        if (av && bv) return m_last ? 2'b10 : 2'b01;
        return {av, bv};
    endfunction

    // One full transfer from the current IDLE cycle through LATCH; ends in cycle 8*DIV+2
    task automatic run_xfer(input bit scr_d, input bit scr_v, input string tag);
        logic [1:0] er;
        logic [7:0] byt;
        logic [5:0] exp_v, got_v;
        bit         g;
        #1;
        er = exp_ready(a_valid, b_valid);
        n_checks++;
        if ({a_ready, b_ready} !== er) begin
            n_fail++;
            $display("FAIL %s ready: got %b expected %b", tag, {a_ready, b_ready}, er);
        end
        if (er == 2'b00) begin
            step();
            return;
        end
        g      = er[0];
        byt    = g ? b_data : a_data;
        m_last = g;
        step();
        for (int unsigned n = 1; n <= 8 * DIV + 1; n++) begin
            if (scr_d) begin
                a_data = 8'($urandom);
                b_data = 8'($urandom);
            end
            if (scr_v) begin
                a_valid = 1'($urandom);
                b_valid = 1'($urandom);
            end
            #1;
            if (n <= 8 * DIV)
                exp_v = {byt[3'(7 - (n - 1) / DIV)], (n % DIV) == 0, 1'b0, 1'b1, 2'b00};
            else
                exp_v = 6'b001100;
            got_v = {sr_data, sr_shift, sr_latch, busy, a_ready, b_ready};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d {data,shift,latch,busy,ar,br}: got %b expected %b",
                         tag, n, got_v, exp_v);
            end
            if (n == 1) begin
                n_checks++;
                if (grant_id !== g) begin
                    n_fail++;
                    $display("FAIL %s grant_id: got %b expected %b", tag, grant_id, g);
                end
            end
            step();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic test_reset();
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;
        step();
        #1;
        n_checks++;
        if ({sr_data, sr_shift, sr_latch, busy, a_ready, b_ready, grant_id} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {sr_data, sr_shift, sr_latch, busy, a_ready, b_ready, grant_id});
        end
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_tie_ready: got %b expected 10", {a_ready, b_ready});
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        rst    = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic test_a5();
        a_valid = 1'b1; a_data = 8'hA5; b_valid = 1'b0;
        run_xfer(1'b0, 1'b0, "a5");
        #1;
        n_checks++;
        if ({a_ready, busy, grant_id} !== 3'b100) begin
            n_fail++;
            $display("FAIL a5_ready_again: got {ar,busy,gid}=%b expected 100", {a_ready, busy, grant_id});
        end
        a_valid = 1'b0;
        step();
    endtask

    task automatic test_tie();
        apply_reset();
        a_data = 8'h3C; b_data = 8'hC3;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 4; i++) run_xfer(1'b0, 1'b0, "tie");
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_b_only();
        a_valid = 1'b0; b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_data = 8'($urandom);
            a_data = 8'($urandom);
            run_xfer(1'b1, 1'b0, "b_only");
        end
        b_valid = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        bit quiet;
        a_valid = 1'b1; a_data = 8'($urandom) | 8'h80; b_valid = 1'b0;
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== exp_ready(1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %b expected 10", {a_ready, b_ready});
        end
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sr_data, sr_shift, sr_latch, busy, a_ready, b_ready, grant_id} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %b expected 0000000",
                     {sr_data, sr_shift, sr_latch, busy, a_ready, b_ready, grant_id});
        end
        step();
        rst    = 1'b0;
        m_last = 1'b1;
        quiet  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if ({sr_data, sr_shift, sr_latch, busy} !== 4'b0) quiet = 1'b0;
            step();
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL mid_reset_abort: got activity after reset expected none");
        end
        b_valid = 1'b1; b_data = 8'($urandom);
        run_xfer(1'b0, 1'b0, "after_reset");
        b_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            a_valid = 1'($urandom);
            b_valid = 1'($urandom);
            a_data  = 8'($urandom);
            b_data  = 8'($urandom);
            run_xfer(1'b1, 1'b1, "random");
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_div2();
        logic [3:0] exp_v, got_v;
        d2_a_valid = 1'b1; d2_a_data = 8'hFF;
        #1;
        n_checks++;
        if ({d2_a_ready, d2_b_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL div2_ready: got %b expected 10", {d2_a_ready, d2_b_ready});
        end
        step();
        d2_a_valid = 1'b0;
        for (int unsigned n = 1; n <= 8 * DIV2 + 2; n++) begin
            #1;
            if (n <= 8 * DIV2)      exp_v = {1'b1, (n % DIV2) == 0, 1'b0, 1'b1};
            else if (n == 8 * DIV2 + 1) exp_v = 4'b0011;
            else                    exp_v = 4'b0000;
            got_v = {d2_sr_data, d2_sr_shift, d2_sr_latch, d2_busy};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL div2 cycle %0d {data,shift,latch,busy}: got %b expected %b", n, got_v, exp_v);
            end
            step();
        end
        n_checks++;
        if (d2_grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL div2_grant_id: got %b expected 0", d2_grant_id);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
        d2_a_valid = 1'b0; d2_b_valid = 1'b0; d2_a_data = 8'h00; d2_b_data = 8'h00;
        test_reset();
        test_a5();
        test_tie();
        test_b_only();
        test_mid_reset();
        test_random();
        test_div2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/shift_register_ctrl.md
SHIFT_REGISTER_CTRL -- requirements
Module: shift_register_ctrl

Interface
REQ-001 Parameter: DIV, default 4, number of clk_sr cycles per serial bit period; legal range 2..255.
REQ-002 clk_sr  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; clears all state immediately on assertion, independent of clk_sr.
REQ-004 a_valid  input  1  requester A holds a byte for transmission.
REQ-005 a_data  input  8  requester A byte; must be stable while a_valid is high.
REQ-006 a_ready  output  1  controller accepts A's byte this cycle.
REQ-007 b_valid  input  1  requester B holds a byte for transmission.
REQ-008 b_data  input  8  requester B byte; must be stable while b_valid is high.
REQ-009 b_ready  output  1  controller accepts B's byte this cycle.
REQ-010 sr_data  output  1  serial bit to the downstream 8-stage shift register.
REQ-011 sr_shift  output  1  single-cycle shift-enable pulse to the shift register.
REQ-012 sr_latch  output  1  single-cycle pulse marking a complete byte in the shift register.
REQ-013 busy  output  1  high in every state other than IDLE.
REQ-014 grant_id  output  1  source of the current or last transfer (0 = A, 1 = B).

Function
REQ-015 FSM states: IDLE, SHIFT, LATCH; no other states are reachable.
REQ-016 IDLE: a_ready/b_ready are combinational, and at most one is high at a time.
REQ-017 Only A valid -> a_ready high; only B valid -> b_ready high; neither valid -> both low.
REQ-018 Both valid -> grant the requester not in last_grant (round-robin).
REQ-019 Handshake = valid & ready at a rising edge; on that edge the controller captures the byte into shreg, updates grant_id and last_grant, clears bit_cnt and div_cnt, and enters SHIFT.
REQ-020 In SHIFT and LATCH, a_ready = b_ready = 0 regardless of valid.
REQ-021 SHIFT, transmission order: sr_data = shreg[7] (MSB first).
REQ-022 SHIFT, divider: div_cnt counts 0..DIV-1 and wraps to 0.
REQ-023 SHIFT, shift pulse: sr_shift = 1 exactly in the cycle where div_cnt == DIV-1; otherwise 0.
REQ-024 SHIFT, bit advance: at the edge ending an sr_shift cycle, shreg shifts left by 1 and bit_cnt increments.
REQ-025 SHIFT -> LATCH at the edge ending the sr_shift cycle with bit_cnt == 7.
REQ-026 Bit timing: with accept edge E0, transmitted bit k (k = 0..7) is driven in cycles k*DIV+1 .. (k+1)*DIV after E0, and sr_shift is high in cycle (k+1)*DIV.
REQ-027 LATCH lasts exactly one cycle, at cycle 8*DIV+1, with sr_latch = 1 and sr_data = 0; then IDLE.
REQ-028 sr_data = 0 in IDLE and LATCH.
REQ-029 Back-to-back: a new handshake is possible in cycle 8*DIV+2 at the earliest; transaction period = 8*DIV+2 cycles.
REQ-030 Valid deasserting mid-transfer has no effect on the transfer in progress.
REQ-031 bit_cnt is 3 bits, div_cnt is 8 bits; neither overflows within a legal DIV.

Reset
REQ-032 rst = 1 -> state = IDLE; shreg, bit_cnt and div_cnt = 0; last_grant = 1 (B), so A wins the first tie.
REQ-033 Reset values: sr_data, sr_shift, sr_latch, busy, grant_id = 0; a_ready/b_ready then follow REQ-016..REQ-018.
REQ-034 rst asserted mid-SHIFT aborts the transfer: no sr_latch, no further sr_shift pulses, and the captured byte is discarded.

Verification
REQ-035 DIV=4, A sends 0xA5 -> sr_data bits 1,0,1,0,0,1,0,1; sr_shift at cycles 4,8,...,32 after accept; sr_latch at cycle 33; a_ready high again at cycle 34.
REQ-036 Both valid from reset (A=0x3C, B=0xC3) -> A served first (grant_id = 0), then B (grant_id = 1), and the A/B order alternates while both stay valid.
REQ-037 B only valid, continuously -> B is granted every transaction at the minimum period of 34 cycles (DIV=4).
REQ-038 Reset at cycle 10 of a transfer -> all outputs 0 immediately, with no clk_sr edge required; the next transfer after release starts cleanly.
REQ-039 DIV=2, A sends 0xFF -> 8 sr_shift pulses spaced 2 cycles apart with sr_data = 1 throughout SHIFT, then sr_latch at cycle 17.
REQ-040 Valid during SHIFT -> ready stays 0 until IDLE; a_data changes while not accepted leave the serial stream unaffected.
